// File: rtl/img_line_buf_ctl.sv
// Image line buffer controller: multi-row store written as wide beats,
// read back as narrow words on NCH independent channels (one bank each).
module img_line_buf_ctl #(
    parameter int WR_W    = 128,
    parameter int RD_W    = 32,
    parameter int ROWS    = 8,
    parameter int NCH     = 2,
    parameter int LINE_WR = 160,
    localparam int R       = WR_W / RD_W,
    localparam int LINE_RD = LINE_WR * R,
    localparam int SLOT_W  = $clog2(ROWS / NCH),
    localparam int WORD_W  = $clog2(LINE_RD),
    localparam int RA_W    = SLOT_W + WORD_W,
    localparam int CNT_W   = $clog2(ROWS + 1)
) (
    input  logic                  clk,
    input  logic                  frst,
    input  logic [WR_W-1:0]       i_wr_data,
    input  logic                  i_wr_vld,
    output logic                  o_wr_rdy,
    input  logic [NCH*RA_W-1:0]   i_rd_addr,
    input  logic                  i_rd_en,
    output logic [NCH*RD_W-1:0]   o_rd_data,
    output logic                  o_rd_vld,
    input  logic                  i_row_rel,
    output logic [CNT_W-1:0]      o_rows_avail,
    output logic                  o_full,
    output logic                  o_err
);

    localparam int LANE_W = $clog2(R);
    localparam int BEAT_W = WORD_W - LANE_W;
    localparam int ROW_W  = $clog2(ROWS);
    localparam int BANK_W = $clog2(NCH);
    localparam int DEPTH  = (ROWS / NCH) << BEAT_W;

    // Control state
    logic [ROW_W-1:0]  wr_row;
    logic [BEAT_W-1:0] wr_col;
    logic [CNT_W-1:0]  rows_avail;
    logic              wr_rdy;
    logic              rd_vld;
    logic              err;

    // Write pipeline stage (one register between accept and RAM update)
    logic                     wr_en_p0;
    logic [BANK_W-1:0]        wr_bank_p0;
    logic [SLOT_W+BEAT_W-1:0] wr_addr_p0;
    logic [WR_W-1:0]          wr_data_p0;
    logic                     row_done_p0;

    logic              accept;
    logic              last_beat;
    logic              pending;
    logic              rel_ok;
    logic              bad_rd;
    logic [CNT_W-1:0]  avail_next;
    logic              rdy_next;

    assign accept    = i_wr_vld & wr_rdy;
    assign last_beat = (wr_col == BEAT_W'(LINE_WR - 1));

    // Next row count and write-ready; a row whose last beat is accepted this
    // cycle is counted as occupied so no beat can slip into a committed row.
    always_comb begin
        rel_ok     = i_row_rel && (rows_avail != '0);
        pending    = accept && last_beat;
        avail_next = rows_avail;
        if (row_done_p0 && !rel_ok)
            avail_next = rows_avail + CNT_W'(1);
        else if (!row_done_p0 && rel_ok)
            avail_next = rows_avail - CNT_W'(1);
        rdy_next = ({1'b0, avail_next} + {{CNT_W{1'b0}}, pending}) < (CNT_W+1)'(ROWS);
    end

    // Flag any read strobe whose word index on some channel is past the row end
    always_comb begin
        bad_rd = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            if (i_rd_en && ({1'b0, i_rd_addr[c*RA_W +: WORD_W]} >= (WORD_W+1)'(LINE_RD)))
                bad_rd = 1'b1;
        end
    end

    // Control registers: write position, row count, ready, read valid, sticky error
    always_ff @(posedge clk) begin
        if (frst) begin
            wr_row      <= '0;
            wr_col      <= '0;
            rows_avail  <= '0;
            wr_rdy      <= 1'b1;
            wr_en_p0    <= 1'b0;
            row_done_p0 <= 1'b0;
            rd_vld      <= 1'b0;
            err         <= 1'b0;
        end else begin
            wr_en_p0    <= accept;
            row_done_p0 <= pending;
            if (accept) begin
                if (last_beat) begin
                    wr_col <= '0;
                    wr_row <= wr_row + ROW_W'(1);
                end else begin
                    wr_col <= wr_col + BEAT_W'(1);
                end
            end
            rows_avail <= avail_next;
            wr_rdy     <= rdy_next;
            rd_vld     <= i_rd_en;
            if ((i_row_rel && rows_avail == '0) || bad_rd)
                err <= 1'b1;
        end
    end

    // Write pipeline data: row r goes to bank r mod NCH, slot r / NCH
    always_ff @(posedge clk) begin
        wr_bank_p0 <= wr_row[BANK_W-1:0];
        wr_addr_p0 <= {wr_row[ROW_W-1:BANK_W], wr_col};
        wr_data_p0 <= i_wr_data;
    end

    for (genvar b = 0; b < NCH; b++) begin : g_bank
        logic [WR_W-1:0]   mem [DEPTH];
        logic [RD_W-1:0]   rd_word;
        logic [SLOT_W-1:0] rd_slot;
        logic [BEAT_W-1:0] rd_beat;
        logic [LANE_W-1:0] rd_lane;

        assign rd_slot = i_rd_addr[b*RA_W + WORD_W +: SLOT_W];
        assign rd_beat = i_rd_addr[b*RA_W + LANE_W +: BEAT_W];
        assign rd_lane = i_rd_addr[b*RA_W +: LANE_W];

        // Bank RAM write from the pipeline stage
        always_ff @(posedge clk) begin
            if (wr_en_p0 && wr_bank_p0 == BANK_W'(b))
                mem[wr_addr_p0] <= wr_data_p0;
        end

        // Registered lane select; holds the last word while the strobe is low
        always_ff @(posedge clk) begin
            if (i_rd_en)
                rd_word <= mem[{rd_slot, rd_beat}][rd_lane*RD_W +: RD_W];
        end

        assign o_rd_data[b*RD_W +: RD_W] = rd_word;
    end

    assign o_wr_rdy     = wr_rdy;
    assign o_rows_avail = rows_avail;
    assign o_full       = (rows_avail == CNT_W'(ROWS));
    assign o_rd_vld     = rd_vld;
    assign o_err        = err;

endmodule

// File: tb/tb_img_line_buf_ctl.sv
// Self-checking bench for img_line_buf_ctl with a row-indexed memory model
// and a read scoreboard.
module tb_img_line_buf_ctl;

    localparam int WR_W    = 128;
    localparam int RD_W    = 32;
    localparam int ROWS    = 8;
    localparam int NCH     = 2;
    localparam int LINE_WR = 160;
    localparam int R       = WR_W / RD_W;
    localparam int LINE_RD = LINE_WR * R;
    localparam int WORD_W  = $clog2(LINE_RD);
    localparam int RA_W    = $clog2(ROWS / NCH) + WORD_W;
    localparam int CNT_W   = $clog2(ROWS + 1);

    logic                clk = 1'b0;
    logic                frst;
    logic [WR_W-1:0]     i_wr_data;
    logic                i_wr_vld;
    logic                o_wr_rdy;
    logic [NCH*RA_W-1:0] i_rd_addr;
    logic                i_rd_en;
    logic [NCH*RD_W-1:0] o_rd_data;
    logic                o_rd_vld;
    logic                i_row_rel;
    logic [CNT_W-1:0]    o_rows_avail;
    logic                o_full;
    logic                o_err;

    img_line_buf_ctl #(
        .WR_W(WR_W), .RD_W(RD_W), .ROWS(ROWS), .NCH(NCH), .LINE_WR(LINE_WR)
    ) dut (
        .clk(clk), .frst(frst),
        .i_wr_data(i_wr_data), .i_wr_vld(i_wr_vld), .o_wr_rdy(o_wr_rdy),
        .i_rd_addr(i_rd_addr), .i_rd_en(i_rd_en),
        .o_rd_data(o_rd_data), .o_rd_vld(o_rd_vld),
        .i_row_rel(i_row_rel), .o_rows_avail(o_rows_avail),
        .o_full(o_full), .o_err(o_err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [WR_W-1:0] model_mem [ROWS][LINE_WR];
    int mrow = 0;
    int mcol = 0;

    typedef struct {
        int            ch;
        logic [RD_W-1:0] exp;
    } rd_exp_t;
    rd_exp_t sb[$];

    function automatic logic [WR_W-1:0] pat(int gen, int row, int col);
        logic [WR_W-1:0] d;
        for (int l = 0; l < R; l++)
            d[l*RD_W +: RD_W] = {8'(gen), 8'(row), 8'(col), 8'(l)};
        return d;
    endfunction

    function automatic logic [RD_W-1:0] exp_word(int row, int w);
        logic [WR_W-1:0] b;
        b = model_mem[row][w / R];
        return b[(w % R)*RD_W +: RD_W];
    endfunction

    task automatic model_write(input logic [WR_W-1:0] d);
        model_mem[mrow][mcol] = d;
        if (mcol == LINE_WR - 1) begin
            mcol = 0;
            mrow = (mrow + 1) % ROWS;
        end else begin
            mcol++;
        end
    endtask

    task automatic do_reset();
        i_wr_vld  = 1'b0;
        i_row_rel = 1'b0;
        i_rd_en   = 1'b0;
        frst      = 1'b1;
        @(posedge clk); #1;
        frst = 1'b0;
        mrow = 0;
        mcol = 0;
    endtask

    task automatic idle(input int n);
        i_wr_vld  = 1'b0;
        i_row_rel = 1'b0;
        i_rd_en   = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Present one beat and hold it until accepted (bounded); leaves i_wr_vld high.
    task automatic write_beat(input logic [WR_W-1:0] d);
        int waitc;
        waitc     = 0;
        i_wr_data = d;
        i_wr_vld  = 1'b1;
        while (o_wr_rdy !== 1'b1 && waitc < 200) begin
            @(posedge clk); #1;
            waitc++;
        end
        if (o_wr_rdy !== 1'b1) begin
            checks++; errors++;
            $display("FAIL write_accept_timeout: o_wr_rdy=%b, required 1", o_wr_rdy);
            i_wr_vld = 1'b0;
        end else begin
            @(posedge clk); #1;
            model_write(d);
        end
    endtask

    // One read strobe on both channels; expected words pushed, then popped on output.
    task automatic rd_cycle(input int s0, input int w0, input bit c0,
                            input int s1, input int w1, input bit c1, input string nm);
        rd_exp_t e;
        i_rd_addr[0 +: RA_W]    = RA_W'((s0 << WORD_W) | w0);
        i_rd_addr[RA_W +: RA_W] = RA_W'((s1 << WORD_W) | w1);
        if (c0) begin e.ch = 0; e.exp = exp_word(s0*NCH + 0, w0); sb.push_back(e); end
        if (c1) begin e.ch = 1; e.exp = exp_word(s1*NCH + 1, w1); sb.push_back(e); end
        i_rd_en = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (o_rd_vld !== 1'b1) begin
            errors++;
            $display("FAIL %s_rd_vld: got %b, required 1", nm, o_rd_vld);
        end
        while (sb.size() != 0) begin
            e = sb.pop_front();
            checks++;
            if (o_rd_data[e.ch*RD_W +: RD_W] !== e.exp) begin
                errors++;
                $display("FAIL %s_ch%0d_data: got %h, required %h", nm, e.ch,
                         o_rd_data[e.ch*RD_W +: RD_W], e.exp);
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (o_rows_avail !== '0) begin errors++; $display("FAIL reset_avail: got %0d, required 0", o_rows_avail); end
        checks++; if (o_full !== 1'b0)     begin errors++; $display("FAIL reset_full: got %b, required 0", o_full); end
        checks++; if (o_wr_rdy !== 1'b1)   begin errors++; $display("FAIL reset_wr_rdy: got %b, required 1", o_wr_rdy); end
        checks++; if (o_rd_vld !== 1'b0)   begin errors++; $display("FAIL reset_rd_vld: got %b, required 0", o_rd_vld); end
        checks++; if (o_err !== 1'b0)      begin errors++; $display("FAIL reset_err: got %b, required 0", o_err); end
    endtask

    task automatic test_first_rows();
        logic [WR_W-1:0] d;
        logic [RD_W-1:0] held;
        write_beat(128'h44444444_33333333_22222222_11111111);
        idle(1);
        checks++; if (o_rd_vld !== 1'b0) begin errors++; $display("FAIL beat0_pre_vld: got %b, required 0", o_rd_vld); end
        rd_cycle(0, 1, 1'b1, 0, 0, 1'b0, "beat0");
        checks++;
        if (o_rd_data[31:0] !== 32'h22222222) begin
            errors++; $display("FAIL beat0_word1: got %h, required 22222222", o_rd_data[31:0]);
        end
        // Read data holds and valid drops once the strobe goes low
        held = o_rd_data[31:0];
        i_rd_en = 1'b0;
        i_rd_addr = '0;
        @(posedge clk); #1;
        checks++; if (o_rd_vld !== 1'b0) begin errors++; $display("FAIL hold_rd_vld: got %b, required 0", o_rd_vld); end
        checks++; if (o_rd_data[31:0] !== held) begin errors++; $display("FAIL hold_rd_data: got %h, required %h", o_rd_data[31:0], held); end

        for (int c = 1; c < LINE_WR; c++) write_beat(pat(0, 0, c));
        i_wr_vld = 1'b0;
        checks++; if (o_rows_avail !== 4'd0) begin errors++; $display("FAIL row0_commit_early: got %0d, required 0", o_rows_avail); end
        @(posedge clk); #1;
        checks++; if (o_rows_avail !== 4'd1) begin errors++; $display("FAIL row0_commit: got %0d, required 1", o_rows_avail); end

        for (int c = 0; c < LINE_WR; c++) begin
            d = pat(0, 1, c);
            if (c == LINE_WR - 1) d[3*RD_W +: RD_W] = 32'hDEADBEEF;
            write_beat(d);
        end
        idle(2);
        checks++; if (o_rows_avail !== 4'd2) begin errors++; $display("FAIL two_rows_avail: got %0d, required 2", o_rows_avail); end
        rd_cycle(0, 5, 1'b1, 0, 639, 1'b1, "row1_last");
        checks++;
        if (o_rd_data[RD_W +: RD_W] !== 32'hDEADBEEF) begin
            errors++; $display("FAIL row1_word639: got %h, required deadbeef", o_rd_data[RD_W +: RD_W]);
        end
        i_rd_en = 1'b0;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++)
            rd_cycle(0, (i*83) % LINE_RD, 1'b1, 0, (i*97 + 3) % LINE_RD, 1'b1, "b2b");
        idle(1);
    endtask

    task automatic test_fill();
        do_reset();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < LINE_WR; c++)
                write_beat(pat(1, r, c));
        checks++; if (o_wr_rdy !== 1'b0)     begin errors++; $display("FAIL fill_rdy_drop: got %b, required 0", o_wr_rdy); end
        checks++; if (o_rows_avail !== 4'd7) begin errors++; $display("FAIL fill_avail_lag: got %0d, required 7", o_rows_avail); end
        // 1281st beat presented and held off
        i_wr_data = pat(9, 0, 0);
        i_wr_vld  = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        checks++; if (o_rows_avail !== 4'd8) begin errors++; $display("FAIL fill_avail: got %0d, required 8", o_rows_avail); end
        checks++; if (o_full !== 1'b1)       begin errors++; $display("FAIL fill_full: got %b, required 1", o_full); end
        checks++; if (o_wr_rdy !== 1'b0)     begin errors++; $display("FAIL fill_rdy: got %b, required 0", o_wr_rdy); end
        i_wr_vld = 1'b0;
        rd_cycle(0, 0, 1'b1, 0, 0, 1'b1, "fill_row01");
        rd_cycle(3, 123, 1'b1, 3, 639, 1'b1, "fill_row67");
        i_rd_en   = 1'b0;
        i_row_rel = 1'b1;
        @(posedge clk); #1;
        i_row_rel = 1'b0;
        checks++; if (o_rows_avail !== 4'd7) begin errors++; $display("FAIL rel_avail: got %0d, required 7", o_rows_avail); end
        checks++; if (o_full !== 1'b0)       begin errors++; $display("FAIL rel_full: got %b, required 0", o_full); end
        checks++; if (o_wr_rdy !== 1'b1)     begin errors++; $display("FAIL rel_rdy: got %b, required 1", o_wr_rdy); end
    endtask

    task automatic test_rel_collision();
        i_row_rel = 1'b1;
        repeat (4) begin @(posedge clk); #1; end
        i_row_rel = 1'b0;
        checks++; if (o_rows_avail !== 4'd3) begin errors++; $display("FAIL rel4_avail: got %0d, required 3", o_rows_avail); end
        for (int c = 0; c < LINE_WR; c++) write_beat(pat(2, 0, c));
        i_wr_vld  = 1'b0;
        i_row_rel = 1'b1;
        checks++; if (o_rows_avail !== 4'd3) begin errors++; $display("FAIL coll_pre_avail: got %0d, required 3", o_rows_avail); end
        @(posedge clk); #1;
        i_row_rel = 1'b0;
        checks++; if (o_rows_avail !== 4'd3) begin errors++; $display("FAIL coll_avail: got %0d, required 3", o_rows_avail); end
        idle(1);
        checks++; if (o_rows_avail !== 4'd3) begin errors++; $display("FAIL coll_avail_after: got %0d, required 3", o_rows_avail); end
        rd_cycle(0, 7, 1'b1, 2, 100, 1'b1, "coll_rows");
        i_rd_en = 1'b0;
    endtask

    task automatic test_err();
        do_reset();
        i_row_rel = 1'b1;
        @(posedge clk); #1;
        i_row_rel = 1'b0;
        checks++; if (o_err !== 1'b1)        begin errors++; $display("FAIL rel_empty_err: got %b, required 1", o_err); end
        checks++; if (o_rows_avail !== 4'd0) begin errors++; $display("FAIL rel_empty_avail: got %0d, required 0", o_rows_avail); end
        idle(3);
        checks++; if (o_err !== 1'b1)        begin errors++; $display("FAIL err_sticky: got %b, required 1", o_err); end
        do_reset();
        checks++; if (o_err !== 1'b0)        begin errors++; $display("FAIL err_cleared: got %b, required 0", o_err); end
        rd_cycle(0, 639, 1'b0, 0, 0, 1'b0, "rd639");
        checks++; if (o_err !== 1'b0)        begin errors++; $display("FAIL rd639_err: got %b, required 0", o_err); end
        rd_cycle(0, 640, 1'b0, 0, 0, 1'b0, "rd640");
        checks++; if (o_err !== 1'b1)        begin errors++; $display("FAIL rd640_err: got %b, required 1", o_err); end
        idle(1);
    endtask

    task automatic test_mid_reset();
        do_reset();
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < LINE_WR; c++)
                write_beat(pat(3, r, c));
        for (int c = 0; c < 50; c++) write_beat(pat(3, 2, c));
        i_wr_vld = 1'b0;
        rd_cycle(0, 700, 1'b0, 0, 0, 1'b0, "pre_rst_bad");
        checks++; if (o_rows_avail !== 4'd2) begin errors++; $display("FAIL pre_rst_avail: got %0d, required 2", o_rows_avail); end
        checks++; if (o_err !== 1'b1)        begin errors++; $display("FAIL pre_rst_err: got %b, required 1", o_err); end
        // Reset with a read strobe still asserted
        frst = 1'b1;
        @(posedge clk); #1;
        frst    = 1'b0;
        i_rd_en = 1'b0;
        mrow = 0;
        mcol = 0;
        checks++; if (o_rows_avail !== '0) begin errors++; $display("FAIL mid_rst_avail: got %0d, required 0", o_rows_avail); end
        checks++; if (o_full !== 1'b0)     begin errors++; $display("FAIL mid_rst_full: got %b, required 0", o_full); end
        checks++; if (o_wr_rdy !== 1'b1)   begin errors++; $display("FAIL mid_rst_rdy: got %b, required 1", o_wr_rdy); end
        checks++; if (o_rd_vld !== 1'b0)   begin errors++; $display("FAIL mid_rst_rd_vld: got %b, required 0", o_rd_vld); end
        checks++; if (o_err !== 1'b0)      begin errors++; $display("FAIL mid_rst_err: got %b, required 0", o_err); end
        write_beat(pat(4, 0, 0));
        idle(1);
        rd_cycle(0, 2, 1'b1, 0, 0, 1'b0, "after_rst_col0");
        rd_cycle(0, 4, 1'b1, 0, 0, 1'b0, "after_rst_col1");
        rd_cycle(1, 200, 1'b1, 0, 0, 1'b0, "after_rst_row2");
        idle(1);
    endtask

    initial begin
        frst      = 1'b1;
        i_wr_data = '0;
        i_wr_vld  = 1'b0;
        i_rd_addr = '0;
        i_rd_en   = 1'b0;
        i_row_rel = 1'b0;
        test_reset();
        test_first_rows();
        test_back_to_back();
        test_fill();
        test_rel_collision();
        test_err();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/img_line_buf_ctl.md
IMG_LINE_BUF_CTL -- requirements
Module: img_line_buf_ctl

Interface
REQ-001 The block SHALL have parameter WR_W, default 128, meaning write beat width in bits.
REQ-002 The block SHALL have parameter RD_W, default 32, meaning read word width in bits; WR_W/RD_W = R, a power of 2.
REQ-003 The block SHALL have parameter ROWS, default 8, meaning rows held; a power of 2 and a multiple of NCH.
REQ-004 The block SHALL have parameter NCH, default 2, meaning read channels and banks; a power of 2.
REQ-005 The block SHALL have parameter LINE_WR, default 160, meaning write beats per row; LINE_RD = LINE_WR*R read words per row.
REQ-006 The block SHALL define localparam RA_W = clog2(ROWS/NCH) + clog2(LINE_RD), which is 12 at defaults.
REQ-007 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-008 The block SHALL have port frst, input, 1 bit: reset, synchronous, active-high.
REQ-009 The block SHALL have port i_wr_data, input, WR_W bits: write beat.
REQ-010 The block SHALL have port i_wr_vld, input, 1 bit: write beat valid.
REQ-011 The block SHALL have port o_wr_rdy, output, 1 bit: block can accept a write beat.
REQ-012 The block SHALL have port i_rd_addr, input, NCH*RA_W bits: per-channel {slot, word}; channel c is at bits [c*RA_W +: RA_W].
REQ-013 The block SHALL have port i_rd_en, input, 1 bit: read strobe common to all channels.
REQ-014 The block SHALL have port o_rd_data, output, NCH*RD_W bits: per-channel read data; channel c is at bits [c*RD_W +: RD_W].
REQ-015 The block SHALL have port o_rd_vld, output, 1 bit: o_rd_data valid.
REQ-016 The block SHALL have port i_row_rel, input, 1 bit: pulse that frees the oldest committed row.
REQ-017 The block SHALL have port o_rows_avail, output, clog2(ROWS+1) bits: number of committed, unreleased rows.
REQ-018 The block SHALL have port o_full, output, 1 bit: o_rows_avail == ROWS.
REQ-019 The block SHALL have port o_err, output, 1 bit: sticky protocol-error flag.

Function
REQ-020 Write accept SHALL occur when i_wr_vld & o_wr_rdy; o_wr_rdy SHALL be registered and equal 1 iff rows_avail < ROWS after the current cycle's update.
REQ-021 Internal wr_row (0..ROWS-1) and wr_col (0..LINE_WR-1) SHALL advance per accepted beat: wr_col wraps at LINE_WR-1 to 0 and wr_row then increments mod ROWS.
REQ-022 Row r SHALL be stored in bank r mod NCH, slot r/NCH; write SHALL be registered one cycle (address, data, bank enable) before RAM update.
REQ-023 Completion of a row (beat wr_col = LINE_WR-1 accepted) SHALL increment rows_avail one cycle after acceptance.
REQ-024 i_row_rel with rows_avail > 0 SHALL decrement rows_avail; completion and release in the same cycle SHALL leave rows_avail unchanged.
REQ-025 i_row_rel with rows_avail == 0 SHALL be ignored and SHALL set o_err.
REQ-026 Channel c SHALL read bank c at slot = i_rd_addr[c][RA_W-1 -: clog2(ROWS/NCH)] and word w = the low bits.
REQ-027 Word w SHALL map to write beat w/R, lane w mod R; lane 0 SHALL be bits [RD_W-1:0] of the beat.
REQ-028 Read latency SHALL be 1 cycle: o_rd_data and o_rd_vld SHALL be valid the cycle after i_rd_en; o_rd_data SHALL hold its value when i_rd_en is low.
REQ-029 An i_rd_en with any channel's w >= LINE_RD SHALL set o_err; o_rd_vld SHALL still assert; that channel's data is don't-care.
REQ-030 Reading the row currently being written SHALL be don't-care; the bench checks only committed rows.
REQ-031 o_err SHALL stay 1 until frst.

Reset
REQ-032 On frst: wr_row=0, wr_col=0, rows_avail=0, o_rows_avail=0, o_full=0, o_wr_rdy=1, o_rd_vld=0, o_err=0, and the write pipeline enable cleared.
REQ-033 RAM contents and o_rd_data SHALL NOT be reset.
REQ-034 frst mid-row SHALL discard the partial row; the next accepted beat SHALL land at row 0, column 0.

Verification
REQ-035 Scenario: write beat 0 of row 0 = 0x44444444_33333333_22222222_11111111, then read ch0 {slot 0, word 1} -> o_rd_data[31:0] = 0x22222222 and o_rd_vld = 1 exactly one cycle later.
REQ-036 Scenario: write row 1 beat 159 lane 3 = 0xDEADBEEF, then read ch1 {slot 0, word 639} -> 0xDEADBEEF.
REQ-037 Scenario: 1280 continuous beats -> o_rows_avail = 8, o_full = 1, o_wr_rdy = 0; 1281st beat is held off; one i_row_rel -> avail = 7, o_wr_rdy = 1 next cycle.
REQ-038 Scenario: i_row_rel in the same cycle the completing beat's count update lands (avail = 3) -> avail stays 3.
REQ-039 Scenario: i_row_rel at avail = 0 -> o_err = 1 and avail stays 0; read word 640 on ch0 -> o_err = 1 and o_rd_vld = 1.
REQ-040 Scenario: frst after 50 beats of row 2 -> all outputs take their reset values; the next beat lands at row 0, column 0, readable via ch0 slot 0.
